// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM encoding and op-class helpers for the seq_alu execution unit.
package seq_alu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD    = 5'h00;
  localparam logic [OP_W-1:0] OP_SUB    = 5'h01;
  localparam logic [OP_W-1:0] OP_AND    = 5'h02;
  localparam logic [OP_W-1:0] OP_OR     = 5'h03;
  localparam logic [OP_W-1:0] OP_SLL    = 5'h04;
  localparam logic [OP_W-1:0] OP_SLT    = 5'h05;
  localparam logic [OP_W-1:0] OP_SLTU   = 5'h06;
  localparam logic [OP_W-1:0] OP_XOR    = 5'h07;
  localparam logic [OP_W-1:0] OP_SRL    = 5'h08;
  localparam logic [OP_W-1:0] OP_SRA    = 5'h09;
  localparam logic [OP_W-1:0] OP_MUL    = 5'h10;
  localparam logic [OP_W-1:0] OP_MULH   = 5'h11;
  localparam logic [OP_W-1:0] OP_MULHSU = 5'h12;
  localparam logic [OP_W-1:0] OP_MULHU  = 5'h13;
  localparam logic [OP_W-1:0] OP_DIV    = 5'h14;
  localparam logic [OP_W-1:0] OP_DIVU   = 5'h15;
  localparam logic [OP_W-1:0] OP_REM    = 5'h16;
  localparam logic [OP_W-1:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_mdu_op(input logic [OP_W-1:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return is_mdu_op(op) && op[2];
  endfunction

endpackage

// File: rtl/seq_alu_mdu.sv
// Iterative multiply/divide on operand magnitudes, one bit per cycle for XLEN cycles.
// start loads operands; done pulses during the last step; res is valid the following cycle.
module seq_alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);

  logic              run;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] p;
  logic [XLEN-1:0]   mb;
  logic [2:0]        fn_q;
  logic              neg_a, neg_b;

  logic              a_sgn, b_sgn, na, nb;
  logic [XLEN-1:0]   ma, mbi;
  logic [XLEN:0]     add_s, div_d;
  logic [2*XLEN-1:0] sprod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    a_sgn = fn[2] ? ~fn[0] : (fn[1:0] != 2'b11);
    b_sgn = fn[2] ? ~fn[0] : ~fn[1];
    na    = a_sgn & a[XLEN-1];
    nb    = b_sgn & b[XLEN-1];
    ma    = na ? -a : a;
    mbi   = nb ? -b : b;
  end

  // p is {partial product | multiplier} for multiply and {remainder | quotient} for divide
  always_comb begin
    add_s = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, mb} : '0);
    div_d = {p[2*XLEN-1:XLEN], p[XLEN-1]} - {1'b0, mb};
  end

  assign done = run && (cnt == CW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run   <= 1'b0;
      cnt   <= '0;
      p     <= '0;
      mb    <= '0;
      fn_q  <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
    end else if (kill) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= '0;
      p     <= {{XLEN{1'b0}}, ma};
      mb    <= mbi;
      fn_q  <= fn;
      neg_a <= na;
      neg_b <= nb;
    end else if (run) begin
      if (fn_q[2])
        p <= div_d[XLEN] ? {p[2*XLEN-2:0], 1'b0} : {div_d[XLEN-1:0], p[XLEN-2:0], 1'b1};
      else
        p <= {add_s, p[XLEN-1:1]};
      cnt <= cnt + 1'b1;
      if (done) begin
        run <= 1'b0;
        cnt <= '0;
      end
    end
  end

  always_comb begin
    sprod = (neg_a ^ neg_b) ? -p : p;
    quo   = p[XLEN-1:0];
    rem   = p[2*XLEN-1:XLEN];
    if (!fn_q[2])
      res = (fn_q[1:0] == 2'b00) ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN];
    else if (fn_q[1])
      res = neg_a ? -rem : rem;
    else
      res = (neg_a ^ neg_b) ? -quo : quo;
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: base ops and divide corner cases in 1 cycle, MUL/DIV in XLEN+2 when SEQ_ALU_MDU_EN is defined.
// Result and flags hold while out_valid && !out_ready; kill flushes to IDLE from any state.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu,
  output logic            illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state;
  logic [XLEN-1:0] imm_res;
  logic            imm_ill;
  logic            lt_c, ltu_c;
  logic [SHW-1:0]  shamt;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign lt_c     = $signed(src_a) < $signed(src_b);
  assign ltu_c    = src_a < src_b;
  assign shamt    = src_b[SHW-1:0];

`ifdef SEQ_ALU_MDU_EN
  logic            go_calc;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_res;
  logic            lt_q, ltu_q;

  seq_alu_mdu #(.XLEN(XLEN)) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .start (in_ready && in_valid && go_calc),
    .kill  (kill),
    .fn    (op[2:0]),
    .a     (src_a),
    .b     (src_b),
    .done  (mdu_done),
    .res   (mdu_res)
  );
`endif

  always_comb begin
    imm_res = '0;
    imm_ill = 1'b0;
`ifdef SEQ_ALU_MDU_EN
    go_calc = 1'b0;
`endif
    case (op)
      OP_ADD:  imm_res = src_a + src_b;
      OP_SUB:  imm_res = src_a - src_b;
      OP_AND:  imm_res = src_a & src_b;
      OP_OR:   imm_res = src_a | src_b;
      OP_XOR:  imm_res = src_a ^ src_b;
      OP_SLL:  imm_res = src_a << shamt;
      OP_SRL:  imm_res = src_a >> shamt;
      OP_SRA:  imm_res = $signed(src_a) >>> shamt;
      OP_SLT:  imm_res = {{(XLEN-1){1'b0}}, lt_c};
      OP_SLTU: imm_res = {{(XLEN-1){1'b0}}, ltu_c};
      default: begin
`ifdef SEQ_ALU_MDU_EN
        // Divide-by-zero and MIN/-1 never enter the iterative path
        if (!is_mdu_op(op))
          imm_ill = 1'b1;
        else if (is_div_op(op) && src_b == '0)
          imm_res = op[1] ? src_a : '1;
        else if (is_div_op(op) && !op[0] && src_a == XMIN && src_b == '1)
          imm_res = op[1] ? '0 : XMIN;
        else
          go_calc = 1'b1;
`else
        imm_ill = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      lt        <= 1'b0;
      ltu       <= 1'b0;
      illegal   <= 1'b0;
`ifdef SEQ_ALU_MDU_EN
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
`endif
    end else if (kill) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
`ifdef SEQ_ALU_MDU_EN
          if (go_calc) begin
            state <= ST_CALC;
            lt_q  <= lt_c;
            ltu_q <= ltu_c;
          end else
`endif
          begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= imm_res;
            zero      <= (imm_res == '0);
            lt        <= lt_c;
            ltu       <= ltu_c;
            illegal   <= imm_ill;
          end
        end
`ifdef SEQ_ALU_MDU_EN
        ST_CALC: if (mdu_done) state <= ST_FIX;
        ST_FIX: begin
          state     <= ST_DONE;
          out_valid <= 1'b1;
          result    <= mdu_res;
          zero      <= (mdu_res == '0);
          lt        <= lt_q;
          ltu       <= ltu_q;
          illegal   <= 1'b0;
        end
`endif
        ST_DONE: if (out_ready) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
